// File: rtl/alu_exec_unit_if.sv
// Execute-stage ALU bus: decoded instruction fields and operands in,
// decoded operation, combinational result and registered result out.
interface alu_exec_unit_if;
  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic        add_rshift_type;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUop;
  logic [31:0] Out;
  logic [31:0] Out_q;

  // Upstream side: supplies instruction fields and operands.
  modport master (
    output opcode,
    output funct,
    output add_rshift_type,
    output A,
    output B,
    input  ALUop,
    input  Out,
    input  Out_q
  );

  // ALU side: consumes fields and operands, returns results.
  modport slave (
    input  opcode,
    input  funct,
    input  add_rshift_type,
    input  A,
    input  B,
    output ALUop,
    output Out,
    output Out_q
  );
endinterface

// File: rtl/alu_exec_unit.sv
// RV32I integer execute unit.
// Decodes opcode/funct3/bit30 into a 4-bit ALU operation and computes the
// 32-bit result combinationally for same-cycle consumers (branch target,
// memory address, writeback mux). A registered copy feeds the next stage.
// Operand selection happens upstream; B arrives already extended.
module alu_exec_unit (
  input  logic            i_clock,
  input  logic            i_reset,
  alu_exec_unit_if.slave  bus
);

  // Operation encodings seen by downstream logic on ALUop.
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRA    = 4'd8,
    ALU_SRL    = 4'd9,
    ALU_COPY_B = 4'd10
  } alu_op_e;

  // Major opcodes that steer the decode.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  alu_op_e     w_alu_op;
  logic        w_is_rtype;
  logic [4:0]  w_shamt;
  logic [31:0] w_out;
  logic [31:0] r_out_q;

  // Only register-register ops honour bit 30 on funct3 000; in I-type it is immediate data.
  assign w_is_rtype = (bus.opcode == OPC_OP);

  // Shift amount is the low five bits of B; upper bits never matter for shifts.
  assign w_shamt = bus.B[4:0];

  // Decode instruction fields into an ALU operation.
  always_comb begin
    w_alu_op = ALU_ADD;
    case (bus.opcode)
      OPC_LUI: begin
        w_alu_op = ALU_COPY_B;
      end
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: begin
        w_alu_op = ALU_ADD;
      end
      OPC_OP, OPC_OP_IMM: begin
        case (bus.funct)
          3'b000: begin
            if (w_is_rtype && bus.add_rshift_type) begin
              w_alu_op = ALU_SUB;
            end else begin
              w_alu_op = ALU_ADD;
            end
          end
          3'b001: w_alu_op = ALU_SLL;
          3'b010: w_alu_op = ALU_SLT;
          3'b011: w_alu_op = ALU_SLTU;
          3'b100: w_alu_op = ALU_XOR;
          3'b101: begin
            if (bus.add_rshift_type) begin
              w_alu_op = ALU_SRA;
            end else begin
              w_alu_op = ALU_SRL;
            end
          end
          3'b110: w_alu_op = ALU_OR;
          3'b111: w_alu_op = ALU_AND;
          default: w_alu_op = ALU_ADD;
        endcase
      end
      default: begin
        w_alu_op = ALU_ADD;
      end
    endcase
  end

  // Compute the result for the decoded operation; unused encodings give zero.
  always_comb begin
    w_out = 32'h0000_0000;
    case (w_alu_op)
      ALU_ADD:    w_out = bus.A + bus.B;
      ALU_SUB:    w_out = bus.A - bus.B;
      ALU_AND:    w_out = bus.A & bus.B;
      ALU_OR:     w_out = bus.A | bus.B;
      ALU_XOR:    w_out = bus.A ^ bus.B;
      ALU_SLT:    w_out = {31'h0000_0000, ($signed(bus.A) < $signed(bus.B))};
      ALU_SLTU:   w_out = {31'h0000_0000, (bus.A < bus.B)};
      ALU_SLL:    w_out = bus.A << w_shamt;
      ALU_SRA:    w_out = $unsigned($signed(bus.A) >>> w_shamt);
      ALU_SRL:    w_out = bus.A >> w_shamt;
      ALU_COPY_B: w_out = bus.B;
      default:    w_out = 32'h0000_0000;
    endcase
  end

  // Pipeline register for the next stage; reset clears it, no stall or enable.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_out_q <= 32'h0000_0000;
    end else begin
      r_out_q <= w_out;
    end
  end

  assign bus.ALUop = w_alu_op;
  assign bus.Out   = w_out;
  assign bus.Out_q = r_out_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed + random bench for alu_exec_unit with a scoreboard queue.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic rst;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  alu_exec_unit_if bus ();

  alu_exec_unit dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] ROP    = 7'b0110011;
  localparam logic [6:0] IOP    = 7'b0010011;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f, input logic b30,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.opcode          = opc;
    bus.funct           = f;
    bus.add_rshift_type = b30;
    bus.A               = a;
    bus.B               = b;
  endtask

  // Drive one vector, check ALUop and Out combinationally, Out_q after the edge.
  task automatic step(input string tag, input logic [6:0] opc, input logic [2:0] f,
                      input logic b30, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] exp_op, input logic [31:0] exp_out);
    drive(opc, f, b30, a, b);
    push_exp({tag, ".op"}, {28'h0000000, exp_op});
    push_exp({tag, ".out"}, exp_out);
    #1;
    check({28'h0000000, bus.ALUop});
    check(bus.Out);
    push_exp({tag, ".q"}, exp_out);
    @(posedge clk);
    #1;
    check(bus.Out_q);
  endtask

  // Reference result by mnemonic; arithmetic shift done bit by bit.
  function automatic logic [31:0] ref_result(input int m, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int          sh;
    sh = int'(b[4:0]);
    case (m)
      0:  r = a + b;
      1:  r = a + (~b) + 32'd1;
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  begin
            if (a[31] != b[31]) r = {31'h0, a[31]};
            else                r = {31'h0, (a < b)};
          end
      6:  r = {31'h0, (a < b)};
      7:  begin r = a; for (int k = 0; k < sh; k++) r = {r[30:0], 1'b0}; end
      8:  begin r = a; for (int k = 0; k < sh; k++) r = {r[31], r[31:1]}; end
      9:  begin r = a; for (int k = 0; k < sh; k++) r = {1'b0, r[31:1]}; end
      10: r = b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Random-loop op table: opcode, funct3, bit30 (2 = don't care), mnemonic code.
  logic [6:0] t_opc  [19] = '{ROP, ROP, ROP, ROP, ROP, ROP, ROP, ROP, ROP, ROP,
                              IOP, IOP, IOP, IOP, IOP, IOP, IOP, IOP, IOP};
  logic [2:0] t_f    [19] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7,
                              3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
  int         t_b30  [19] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0,
                              2, 0, 0, 0, 0, 0, 1, 0, 0};
  int         t_mn   [19] = '{0, 1, 7, 5, 6, 4, 9, 8, 3, 2,
                              0, 7, 5, 6, 4, 9, 8, 3, 2};

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rb30;
    int          idx;
    logic [6:0]  nonalu [6];

    rst = 1'b1;
    bus.opcode = 7'h00; bus.funct = 3'h0; bus.add_rshift_type = 1'b0;
    bus.A = 32'h0; bus.B = 32'h0;

    // Reset held for two edges clears Out_q.
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset.q", 32'h0);
    check(bus.Out_q);

    // Release reset with AND: Out immediate, Out_q one edge later.
    @(negedge clk);
    rst = 1'b0;
    bus.opcode = ROP; bus.funct = 3'b111; bus.add_rshift_type = 1'b0;
    bus.A = 32'hF0F0F0F0; bus.B = 32'hFF00FF00;
    #1;
    push_exp("and.out", 32'hF000F000);
    check(bus.Out);
    push_exp("and.op", 32'd2);
    check({28'h0, bus.ALUop});
    push_exp("and.q_before_edge", 32'h0);
    check(bus.Out_q);
    @(posedge clk);
    #1;
    push_exp("and.q", 32'hF000F000);
    check(bus.Out_q);

    // Reset mid-stream clears Out_q, leaves Out alone; release recaptures.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_exp("midreset.q", 32'h0);
    check(bus.Out_q);
    push_exp("midreset.out", 32'hF000F000);
    check(bus.Out);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_exp("release.q", 32'hF000F000);
    check(bus.Out_q);

    // Non-ALU opcodes with random funct and bit 30.
    step("lui", LUI, 3'($urandom_range(7)), 1'($urandom_range(1)),
         32'h80000005, 32'hFFFF8003, 4'd10, 32'hFFFF8003);
    nonalu = '{AUIPC, JAL, JALR, BRANCH, LOAD, STORE};
    foreach (nonalu[i]) begin
      step($sformatf("addop%0d", i), nonalu[i], 3'($urandom_range(7)), 1'($urandom_range(1)),
           32'h80000005, 32'hFFFF8003, 4'd0, 32'h7FFF8008);
    end
    step("other_opc", 7'b1110011, 3'd5, 1'b1, 32'h80000005, 32'hFFFF8003, 4'd0, 32'h7FFF8008);

    // R-type add / sub.
    step("r_add", ROP, 3'd0, 1'b0, 32'h80000005, 32'hFFFF8003, 4'd0, 32'h7FFF8008);
    step("r_sub", ROP, 3'd0, 1'b1, 32'h80000005, 32'hFFFF8003, 4'd1, 32'h80008002);

    // Shifts with shamt 4 taken from a B whose upper bits are set.
    step("srl", ROP, 3'd5, 1'b0, 32'h80000000, 32'hFFFFFFE4, 4'd9, 32'h08000000);
    step("sra", ROP, 3'd5, 1'b1, 32'h80000000, 32'hFFFFFFE4, 4'd8, 32'hF8000000);
    step("sll", ROP, 3'd1, 1'b0, 32'h00000001, 32'hFFFFFFE4, 4'd7, 32'h00000010);

    // Signed versus unsigned compares.
    step("slt",   ROP, 3'd2, 1'b0, 32'h80000000, 32'h1, 4'd5, 32'h1);
    step("slti",  IOP, 3'd2, 1'b0, 32'h80000000, 32'h1, 4'd5, 32'h1);
    step("sltu",  ROP, 3'd3, 1'b0, 32'h80000000, 32'h1, 4'd6, 32'h0);
    step("sltiu", IOP, 3'd3, 1'b0, 32'h80000000, 32'h1, 4'd6, 32'h0);
    step("slt2",  ROP, 3'd2, 1'b0, 32'h1, 32'hFFFFFFFF, 4'd5, 32'h0);
    step("sltu2", ROP, 3'd3, 1'b0, 32'h1, 32'hFFFFFFFF, 4'd6, 32'h1);

    // I-type: bit 30 is immediate data for addi, selects SRA for shifts.
    step("addi_b30", IOP, 3'd0, 1'b1, 32'h1, 32'h2, 4'd0, 32'h3);
    step("srai", IOP, 3'd5, 1'b1, 32'h80000000, 32'h00000404, 4'd8, 32'hF8000000);

    // Random loop over all R/I ops with negative operands.
    for (int it = 0; it < 40; it++) begin
      idx  = (it < 19) ? it : int'($urandom_range(18));
      ra   = $urandom | 32'h80000000;
      rb   = $urandom | 32'h80000000;
      rb30 = (t_b30[idx] == 2) ? 1'($urandom_range(1)) : 1'(t_b30[idx]);
      step($sformatf("rand%0d_m%0d", it, t_mn[idx]), t_opc[idx], t_f[idx], rb30, ra, rb,
           4'(t_mn[idx]), ref_result(t_mn[idx], ra, rb));
    end

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
